par2srl_tx: RTL and testbench
=============================

Name: par2srl_tx

Overview:
- Parallel-to-serial transmitter that feeds the 4-bit serial-to-parallel receiver stage.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out LSB-first, one bit per clk.
- Drives a per-bit valid and a start-of-frame pulse so the downstream receiver can align its bit counter.
- A one-word holding register allows gapless back-to-back frames.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_  input  1  asynchronous active-low reset
- in_data  input  WIDTH  parallel word to transmit
- in_vld  input  1  in_data is valid
- in_rdy  output  1  block can accept a word this cycle
- srl  output  1  serial data bit, LSB first
- srl_vld  output  1  srl carries a frame bit this cycle
- sof  output  1  high on the first bit (bit 0) of each frame
- busy  output  1  shifter active or holding register occupied

Behaviour:
- Clock and reset: one clock, clk; reset rst_ is asynchronous, active-low.
- Reset values:
  - State IDLE; shift register, bit counter and holding register cleared; hold_vld = 0.
  - Outputs: srl = 0, srl_vld = 0, sof = 0, busy = 0, in_rdy = 1.
  - Reset asserted mid-frame aborts the frame immediately; the partial frame and any held word are discarded.
- Handshake:
  - in_rdy = !hold_vld, decoded from registered state only (no combinational path from in_vld).
  - Transfer occurs when in_vld && in_rdy at a rising edge.
  - in_data is sampled only on a transfer.
- Frame length: FRAME = WIDTH bits (WIDTH+1 with the optional feature enabled).
- Bit counter: log2-sized, counts 0..FRAME-1 and wraps to 0.
- States:
  - IDLE: srl_vld = 0, srl = 0. On a transfer, load in_data into the shift register, set counter = 0, go to SHIFT. First bit appears on srl in the next cycle (1-cycle latency).
  - SHIFT: srl = shreg[0], srl_vld = 1, sof = (cnt == 0).
    - cnt < FRAME-1: shift right one bit, cnt++.
    - cnt == FRAME-1 (last bit): select the next word, in priority order:
      - hold_vld = 1: load the held word, clear hold_vld, cnt = 0, stay in SHIFT.
      - else, transfer this cycle: load in_data directly, cnt = 0, stay in SHIFT.
      - else: go to IDLE.
- Transfer during SHIFT at a cycle that is not the last bit: word goes to the holding register, hold_vld = 1.
- Simultaneous last bit and hold_vld = 1: in_rdy is already 0, so there is no conflict. The held word loads, and in_rdy rises in the next cycle.
- Throughput: one word per FRAME cycles with no idle cycle between frames while upstream keeps the holding register filled.
- busy = (state == SHIFT) || hold_vld.

Optional Feature:
- Macro: PAR2SRL_PARITY_EN.
- Defined:
  - FRAME = WIDTH+1.
  - After bit WIDTH-1, one even-parity bit is sent: XOR of the word, captured at load time. It is sent with srl_vld = 1, sof = 0.
  - Selection of the next word occurs on the parity bit.
- Undefined:
  - FRAME = WIDTH; no parity logic is present.

Test Plan:
- Reset then idle: rst_ low for 3 cycles, then release, in_vld = 0 → srl = 0, srl_vld = 0, sof = 0, busy = 0, in_rdy = 1 throughout.
- Single word, WIDTH = 4: in_data = 4'b1011, one-cycle transfer in IDLE → next 4 cycles srl = 1,1,0,1 with srl_vld = 1; sof high on the first of them only. Then IDLE with busy = 0.
- Back-to-back: in_vld held high with words 4'hA, 4'h5, 4'h3 → serial stream 0,1,0,1,1,0,1,0,1,1,0,0 with no srl_vld gap. sof every 4th cycle; in_rdy low while hold is full.
- Last-bit direct load: hold empty, second word 4'h6 presented exactly on the last bit of frame 4'hF → frame 4'h6 starts the next cycle, no gap, hold_vld never set.
- Reset mid-frame: assert rst_ after 2 bits of 4'h9 with 4'hC held → outputs go to reset values immediately. After release, neither word is transmitted.
- Parity (PAR2SRL_PARITY_EN defined): send 4'b0111 → srl = 1,1,1,0 then parity 1 (5 bits, sof on the first only). Send 4'b0011 → parity bit 0.

Source files
------------

// File: rtl/par2srl_tx.sv
// rtl/par2srl_tx.sv - LSB-first parallel-to-serial transmitter with one-word holding register (optional parity: PAR2SRL_PARITY_EN)
module par2srl_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic             srl,
    output logic             srl_vld,
    output logic             sof,
    output logic             busy
);

`ifdef PAR2SRL_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, nxt_state;
    logic [FRAME-1:0] shreg, nxt_shreg;
    logic [CW-1:0]    cnt, nxt_cnt;
    logic [WIDTH-1:0] hold, nxt_hold;
    logic             hold_vld, nxt_hold_vld;
    logic             xfer;

    // The parity bit rides above the data bits so the plain shift delivers it last.
    function automatic logic [FRAME-1:0] load_word(input logic [WIDTH-1:0] w);
`ifdef PAR2SRL_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    // in_rdy is a register equal to !hold_vld, so no path from in_vld reaches it.
    assign xfer = in_vld && in_rdy;

    // Next-state decode: shift, refill from hold or input on the last bit, or park the word in hold.
    always_comb begin
        nxt_state    = state;
        nxt_shreg    = shreg;
        nxt_cnt      = cnt;
        nxt_hold     = hold;
        nxt_hold_vld = hold_vld;
        case (state)
            IDLE: begin
                if (xfer) begin
                    nxt_shreg = load_word(in_data);
                    nxt_cnt   = '0;
                    nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    nxt_cnt = '0;
                    if (hold_vld) begin
                        nxt_shreg    = load_word(hold);
                        nxt_hold_vld = 1'b0;
                    end else if (xfer) begin
                        nxt_shreg = load_word(in_data);
                    end else begin
                        nxt_shreg = '0;
                        nxt_state = IDLE;
                    end
                end else begin
                    nxt_shreg = {1'b0, shreg[FRAME-1:1]};
                    nxt_cnt   = cnt + 1'b1;
                    if (xfer) begin
                        nxt_hold     = in_data;
                        nxt_hold_vld = 1'b1;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State and registered outputs, derived from the next-state values so they line up with shreg/cnt.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            srl      <= 1'b0;
            srl_vld  <= 1'b0;
            sof      <= 1'b0;
            busy     <= 1'b0;
            in_rdy   <= 1'b1;
        end else begin
            state    <= nxt_state;
            shreg    <= nxt_shreg;
            cnt      <= nxt_cnt;
            hold     <= nxt_hold;
            hold_vld <= nxt_hold_vld;
            srl      <= (nxt_state == SHIFT) ? nxt_shreg[0] : 1'b0;
            srl_vld  <= (nxt_state == SHIFT);
            sof      <= (nxt_state == SHIFT) && (nxt_cnt == '0);
            busy     <= (nxt_state == SHIFT) || nxt_hold_vld;
            in_rdy   <= !nxt_hold_vld;
        end
    end

endmodule

// File: tb/tb_par2srl_tx.sv
// tb/tb_par2srl_tx.sv - directed self-checking bench for par2srl_tx
module tb_par2srl_tx;

    logic       clk;
    logic       rst_;
    logic [3:0] in_data;
    logic       in_vld;
    logic       in_rdy;
    logic       srl;
    logic       srl_vld;
    logic       sof;
    logic       busy;

    int n_chk;
    int n_pass;

    logic [3:0]  words [0:3];
    int          pre   [0:3];
    logic [31:0] cap_srl, cap_vld, cap_sof, cap_busy, cap_rdy;

    par2srl_tx #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .in_data (in_data),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .srl     (srl),
        .srl_vld (srl_vld),
        .sof     (sof),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_srl"},  {31'd0, srl},     32'd0);
        chk({tag, "_vld"},  {31'd0, srl_vld}, 32'd0);
        chk({tag, "_sof"},  {31'd0, sof},     32'd0);
        chk({tag, "_busy"}, {31'd0, busy},    32'd0);
        chk({tag, "_rdy"},  {31'd0, in_rdy},  32'd1);
    endtask

    // Presents words[0..nw-1], word i after pre[i] idle cycles, honouring in_rdy; captures outputs per cycle.
    task automatic run(input int nw, input int ncyc);
        int  wi;
        int  g;
        logic acc;
        wi = 0;
        g  = (nw > 0) ? pre[0] : 0;
        cap_srl = '0; cap_vld = '0; cap_sof = '0; cap_busy = '0; cap_rdy = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (wi < nw && g == 0) begin
                in_vld  = 1'b1;
                in_data = words[wi];
            end else begin
                in_vld = 1'b0;
                if (g > 0) g--;
            end
            acc = in_vld && in_rdy;
            step();
            cap_srl[c]  = srl;
            cap_vld[c]  = srl_vld;
            cap_sof[c]  = sof;
            cap_busy[c] = busy;
            cap_rdy[c]  = in_rdy;
            if (acc) begin
                wi++;
                if (wi < nw) g = pre[wi];
            end
        end
        in_vld = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_    = 1'b0;
        in_vld  = 1'b0;
        in_data = 4'h0;
        for (int i = 0; i < 4; i++) pre[i] = 0;

        for (int i = 0; i < 3; i++) step();
        chk_idle("rst_hold");
        rst_ = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_idle("post_rst");

`ifdef PAR2SRL_PARITY_EN
        words[0] = 4'b0111; words[1] = 4'b0011;
        run(2, 11);
        chk("par_srl", cap_srl & 32'h7FF, 32'h077);
        chk("par_vld", cap_vld & 32'h7FF, 32'h3FF);
        chk("par_sof", cap_sof & 32'h7FF, 32'h021);
`else
        words[0] = 4'b1011;
        run(1, 6);
        chk("single_srl",  cap_srl  & 32'h1F, 32'h0B);
        chk("single_vld",  cap_vld  & 32'h1F, 32'h0F);
        chk("single_sof",  cap_sof  & 32'h1F, 32'h01);
        chk("single_busy", cap_busy & 32'h3F, 32'h0F);

        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'h3;
        run(3, 14);
        chk("b2b_srl", cap_srl & 32'h1FFF, 32'h035A);
        chk("b2b_vld", cap_vld & 32'h1FFF, 32'h0FFF);
        chk("b2b_sof", cap_sof & 32'h1FFF, 32'h0111);
        chk("b2b_rdy", cap_rdy & 32'h3,    32'h1);

        words[0] = 4'hF; words[1] = 4'h6; pre[1] = 3;
        run(2, 10);
        pre[1] = 0;
        chk("last_srl", cap_srl & 32'h1FF, 32'h06F);
        chk("last_vld", cap_vld & 32'h1FF, 32'h0FF);
        chk("last_sof", cap_sof & 32'h1FF, 32'h011);
        chk("last_rdy", cap_rdy & 32'h1FF, 32'h1FF);
`endif

        words[0] = 4'h9; words[1] = 4'hC;
        run(2, 2);
        chk("mid_pre_rdy", {31'd0, in_rdy}, 32'd0);
        rst_ = 1'b0;
        #1;
        chk_idle("mid_rst");
        step();
        step();
        rst_ = 1'b1;
        run(0, 10);
        chk("after_rst_vld",  cap_vld  & 32'h3FF, 32'h0);
        chk("after_rst_busy", cap_busy & 32'h3FF, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
